// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types.
// Includes the memory arbiter state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_INSTR = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    DATA  = ST_DATA,
    INSTR = ST_INSTR,
    DONE  = ST_DONE
  } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up counter that sticks at its maximum value.
// Synchronous active-high clear.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for IF/MEM stages.
// Data access is served before fetch; stall holds the pipe.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       stall_cnt
);

  arb_state_t        state;
  arb_state_t        state_nx;
  logic              req_nx;
  logic              we_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx;
  logic [DATA_W-1:0] if_nx;
  logic [DATA_W-1:0] d_nx;

  assign stall = (state != DONE) &&
                 (d_read || d_write || if_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_nx;
      mem_req   <= req_nx;
      mem_we    <= we_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      if_rdata  <= if_nx;
      d_rdata   <= d_nx;
    end
  end

  always_comb begin
    state_nx = state;
    req_nx   = mem_req;
    we_nx    = mem_we;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    if_nx    = if_rdata;
    d_nx     = d_rdata;
    unique case (state)
      IDLE: begin
        if (d_read || d_write) begin
          state_nx = DATA;
          req_nx   = 1'b1;
          we_nx    = d_write;
          addr_nx  = d_addr;
          wdata_nx = d_wdata;
        end else if (if_req) begin
          state_nx = INSTR;
          req_nx   = 1'b1;
          we_nx    = 1'b0;
          addr_nx  = if_addr;
        end
      end
      DATA: begin
        if (mem_ack) begin
          if (!mem_we)
            d_nx = mem_rdata;
          // req stays high; the address change starts the fetch
          if (if_req) begin
            state_nx = INSTR;
            we_nx    = 1'b0;
            addr_nx  = if_addr;
          end else begin
            state_nx = DONE;
            req_nx   = 1'b0;
          end
        end
      end
      INSTR: begin
        if (mem_ack) begin
          if_nx    = mem_rdata;
          state_nx = DONE;
          req_nx   = 1'b0;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
    endcase
  end

  sat_counter #(
    .WIDTH(32)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter.
// Memory model acks after a programmable wait.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] stall_cnt;

  logic [31:0] mem [256];
  int          lat;
  int          wcnt;
  logic        force_ack;

  int checks = 0;
  int errors = 0;
  int nstall;
  logic [31:0] exp_cnt;
  logic [31:0] q_if [$];
  logic [31:0] q_d [$];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall_cnt(stall_cnt)
  );

  assign mem_ack = force_ack || (mem_req && (wcnt == lat));
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_req || mem_ack)
      wcnt <= 0;
    else
      wcnt <= wcnt + 1;
    if (mem_req && mem_ack && mem_we)
      mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (stall) nstall++;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (stall) begin
      if (k == 50) begin
        checks++;
        errors++;
        $error("FAIL timeout observed=stall expected=done");
        break;
      end
      cyc();
      k++;
    end
  endtask

  task automatic pop_chk(input string tag,
                         input logic [31:0] obs,
                         input bit is_if);
    logic [31:0] e;
    if (is_if) begin
      if (q_if.size() == 0) begin
        checks++; errors++;
        $error("FAIL %s observed=empty expected=entry", tag);
        return;
      end
      e = q_if.pop_front();
    end else begin
      if (q_d.size() == 0) begin
        checks++; errors++;
        $error("FAIL %s observed=empty expected=entry", tag);
        return;
      end
      e = q_d.pop_front();
    end
    chk(tag, obs, e);
  endtask

  task automatic drive_idle();
    if_req  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'hbad0bad0;
    mem[16] = 32'h8c220004;
    mem[17] = 32'h00000020;
    mem[64] = 32'hdeadbeef;
    wcnt = 0;
    lat = 0;
    force_ack = 1'b0;
    rst = 1'b1;
    drive_idle();
    if_addr = '0;
    d_addr  = '0;
    d_wdata = '0;
    exp_cnt = 0;
    nstall = 0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_stall", {31'b0, stall}, 32'd0);
      chk("idle_mem_req", {31'b0, mem_req}, 32'd0);
    end
    chk("idle_stall_cnt", stall_cnt, 32'd0);

    // fetch only, ack two cycles after mem_req
    lat = 2;
    nstall = 0;
    @(posedge clk); #1;
    if_req = 1'b1;
    if_addr = 32'h40;
    q_if.push_back(32'h8c220004);
    exp_cnt += 4;
    cyc();
    cyc();
    chk("f_mem_req", {31'b0, mem_req}, 32'd1);
    chk("f_mem_we", {31'b0, mem_we}, 32'd0);
    chk("f_mem_addr", mem_addr, 32'h40);
    wait_done();
    chk("f_stall_cycles", nstall, 32'd4);
    pop_chk("f_if_rdata", if_rdata, 1'b1);
    chk("f_stall_cnt", stall_cnt, exp_cnt);
    @(posedge clk); #1;
    drive_idle();

    // load plus fetch, zero-wait memory
    lat = 0;
    nstall = 0;
    @(posedge clk); #1;
    d_read = 1'b1;
    d_addr = 32'h100;
    if_req = 1'b1;
    if_addr = 32'h44;
    q_d.push_back(32'hdeadbeef);
    q_if.push_back(32'h00000020);
    exp_cnt += 3;
    cyc();
    cyc();
    chk("lf_data_addr", mem_addr, 32'h100);
    chk("lf_data_we", {31'b0, mem_we}, 32'd0);
    cyc();
    chk("lf_fetch_req", {31'b0, mem_req}, 32'd1);
    chk("lf_fetch_addr", mem_addr, 32'h44);
    pop_chk("lf_d_rdata", d_rdata, 1'b0);
    wait_done();
    chk("lf_stall_cycles", nstall, 32'd3);
    pop_chk("lf_if_rdata", if_rdata, 1'b1);
    chk("lf_stall_cnt", stall_cnt, exp_cnt);
    @(posedge clk); #1;
    drive_idle();

    // store, one wait cycle
    lat = 1;
    nstall = 0;
    @(posedge clk); #1;
    d_write = 1'b1;
    d_addr = 32'h200;
    d_wdata = 32'h12345678;
    q_d.push_back(32'hdeadbeef);
    exp_cnt += 3;
    cyc();
    cyc();
    chk("st_mem_we", {31'b0, mem_we}, 32'd1);
    chk("st_mem_addr", mem_addr, 32'h200);
    chk("st_mem_wdata", mem_wdata, 32'h12345678);
    wait_done();
    chk("st_stall_cycles", nstall, 32'd3);
    pop_chk("st_d_rdata_hold", d_rdata, 1'b0);
    chk("st_mem_written", mem[128], 32'h12345678);
    chk("st_stall_cnt", stall_cnt, exp_cnt);
    @(posedge clk); #1;
    drive_idle();

    // read and write together: write wins
    lat = 0;
    nstall = 0;
    @(posedge clk); #1;
    d_read = 1'b1;
    d_write = 1'b1;
    d_addr = 32'h204;
    d_wdata = 32'hcafef00d;
    q_d.push_back(32'hdeadbeef);
    exp_cnt += 2;
    cyc();
    cyc();
    chk("rw_mem_we", {31'b0, mem_we}, 32'd1);
    wait_done();
    chk("rw_stall_cycles", nstall, 32'd2);
    pop_chk("rw_d_rdata_hold", d_rdata, 1'b0);
    chk("rw_mem_written", mem[129], 32'hcafef00d);
    chk("rw_stall_cnt", stall_cnt, exp_cnt);
    @(posedge clk); #1;
    drive_idle();

    // stray ack while idle must not capture
    @(posedge clk); #1;
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_d", d_rdata, 32'hdeadbeef);
    chk("idle_ack_if", if_rdata, 32'h00000020);
    chk("idle_ack_req", {31'b0, mem_req}, 32'd0);

    // reset in the middle of a fetch
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rr_if_rdata_clr", if_rdata, 32'd0);
    lat = 100;
    @(posedge clk); #1;
    if_req = 1'b1;
    if_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    chk("rr_req_before", {31'b0, mem_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    if_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    chk("rr_req_dropped", {31'b0, mem_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    chk("rr_if_rdata", if_rdata, 32'd0);
    chk("rr_idle_req", {31'b0, mem_req}, 32'd0);
    chk("rr_stall", {31'b0, stall}, 32'd0);
    chk("rr_stall_cnt", stall_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and pipeline sequencer for the 5-stage MIPS pipeline. It shares one unified memory port between the IF stage (instruction fetch) and the MEM stage (data access driven by the EX/MEM register's memread/memwrite/alu_result/rdata2out). It holds a global `stall` to freeze the pipeline registers until every pending access has completed. The data request always wins over fetch, because it belongs to the older instruction.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF stage requests an instruction fetch
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction; registered, held until the next fetch capture
- d_read  in  1  MEM stage load (EX/MEM memread)
- d_write  in  1  MEM stage store (EX/MEM memwrite)
- d_addr  in  ADDR_W  data address (EX/MEM alu_result)
- d_wdata  in  DATA_W  store data (EX/MEM rdata2out)
- d_rdata  out  DATA_W  load data; registered, held until the next load capture
- stall  out  1  freeze all pipeline registers and the PC
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse from memory
- stall_cnt  out  32  saturating count of stalled cycles

## Operation
Four states, with registered outputs:
- **IDLE**
  - if d_read|d_write: latch d_addr, d_wdata, and we = d_write; go to DATA.
  - else if if_req: latch if_addr with we = 0; go to INSTR.
  - else stay in IDLE.
- **DATA**
  - mem_req = 1 with the latched address, data and we.
  - On mem_ack: if the access was a read, capture mem_rdata into d_rdata.
  - Then, if if_req: latch if_addr and go to INSTR. Else go to DONE.
- **INSTR**
  - mem_req = 1, mem_we = 0.
  - On mem_ack: capture mem_rdata into if_rdata and go to DONE.
- **DONE**
  - Lasts exactly one cycle; the pipeline advances in this cycle.
  - Request inputs are ignored; the next state is always IDLE.

Stall rule:
- stall = (state != DONE) && (d_read | d_write | if_req), combinational.
- With no requests in IDLE, stall = 0 and the pipeline free-runs.

Edge cases:
- d_read and d_write both high: treated as a store (write wins).
- mem_ack in IDLE or DONE is ignored, with no capture.
- Request inputs that change during DATA or INSTR do not affect the latched access.
- stall_cnt increments on every cycle with stall = 1 and saturates at 0xFFFFFFFF.

Reset values:
- state = IDLE
- mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
- if_rdata = 0, d_rdata = 0, stall_cnt = 0
- Reset in any state aborts the access, and mem_req drops on the next edge.
- A late mem_ack after reset is ignored.

## Timing
- A request first seen in IDLE at cycle T is driven with mem_req = 1 from cycle T+1.
- The memory may ack in the same cycle mem_req rises (zero wait).
- Data only, ack at cycle A: stall is high for cycles T..A, DONE is at A+1, and d_rdata is valid from A+1. Minimum stall is 2 cycles.
- Fetch only: same timing as data only.
- Both requests:
  - Data is serviced from T+1 and acked at A1.
  - The fetch is issued at A1+1; mem_req stays high, so the memory treats the address change as a new request.
  - Fetch ack at A2; DONE at A2+1.
- mem_addr, mem_wdata and mem_we are stable for the whole time mem_req is high on a given access.
- if_rdata and d_rdata change only on the edge that ends an acked cycle.

## Structure
- State encoding localparams (IDLE = 0, DATA = 1, INSTR = 2, DONE = 3) live in the shared package mips_pkg, next to the pipeline control constants.
- Sub-module sat_counter (parameter width 32; inputs inc and rst) implements stall_cnt.
- Everything else is flat in mem_arbiter.

## Test plan
- **Idle pipeline:** no requests for 10 cycles -> stall = 0, mem_req = 0, stall_cnt = 0.
- **Fetch only:** if_req = 1, if_addr = 0x40; memory acks 2 cycles after mem_req with 0x8C220004 -> mem_req, mem_we = 0 and mem_addr = 0x40 from T+1; ack at T+3 -> stall high for 4 cycles; if_rdata = 0x8C220004 and DONE at T+4.
- **Load plus fetch:** d_read = 1, d_addr = 0x100 and if_req = 1 with if_addr = 0x44, zero-wait memory returning 0xDEADBEEF then 0x00000020 ->
  - data is serviced first: d_rdata = 0xDEADBEEF;
  - mem_addr = 0x44 next;
  - if_rdata = 0x00000020;
  - stall = 1 for 3 cycles, stall_cnt = 3.
- **Store:** d_write = 1, d_addr = 0x200, d_wdata = 0x12345678 -> mem_we = 1, mem_wdata = 0x12345678, and d_rdata is unchanged after the ack.
- **Both read and write:** d_read = d_write = 1 -> mem_we = 1.
- **Reset mid-access:** rst in INSTR before the ack -> mem_req = 0 next cycle; an ack arriving afterward leaves if_rdata = 0; state is IDLE.
